// File: rtl/lcd_char_ctrl.sv
// HD44780-class character LCD controller, 4-bit write-only interface.
// Holds a ROWS x COLS character buffer and refreshes it to the panel continuously.
module lcd_char_ctrl #(
  parameter int ROWS            = 2,
  parameter int COLS            = 16,
  parameter int NIB_CYCLES      = 8192,
  parameter int INIT_NIB_CYCLES = 524288,
  parameter int POR_CYCLES      = 1000000,
  parameter int AW              = $clog2(ROWS*COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          blank,
  output logic          ready,
  output logic          frame_done,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_e,
  output logic [3:0]    lcd_d
);

  // state    | meaning
  // POR_WAIT | power-on settle, all pins low
  // INIT     | twelve slow nibbles bringing the panel into 4-bit mode
  // REFRESH  | endless cursor-command + character stream, row by row

  localparam int DEPTH = ROWS * COLS;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int MAX_A = (POR_CYCLES > INIT_NIB_CYCLES) ? POR_CYCLES : INIT_NIB_CYCLES;
  localparam int MAXN  = (MAX_A > NIB_CYCLES) ? MAX_A : NIB_CYCLES;
  localparam int CW    = $clog2(MAXN + 1);

  localparam logic [CW-1:0]  POR_LAST   = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0]  INIT_LAST  = CW'(INIT_NIB_CYCLES - 1);
  localparam logic [CW-1:0]  INIT_E_ON  = CW'(INIT_NIB_CYCLES / 4);
  localparam logic [CW-1:0]  INIT_E_OFF = CW'((3 * INIT_NIB_CYCLES) / 4);
  localparam logic [CW-1:0]  NIB_LAST   = CW'(NIB_CYCLES - 1);
  localparam logic [CW-1:0]  NIB_E_ON   = CW'(NIB_CYCLES / 4);
  localparam logic [CW-1:0]  NIB_E_OFF  = CW'((3 * NIB_CYCLES) / 4);
  localparam logic [AW:0]    DEPTH_A    = (AW+1)'(DEPTH);
  localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS - 1);
  localparam logic [CLW-1:0] COL_LAST   = CLW'(COLS - 1);
  localparam logic [7:0]     COLS_B     = 8'(COLS);

  typedef enum logic [1:0] {POR_WAIT, INIT, REFRESH} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [3:0]     init_idx;
  logic [RW-1:0]  row;
  logic [CLW-1:0] col;
  logic           is_cmd;
  logic           lo;
  logic [7:0]     hold;
  logic [7:0]     char_mem [DEPTH];

  logic [CW-1:0]  slot_last;
  logic [CW-1:0]  e_on;
  logic [CW-1:0]  e_off;
  logic           e_win;
  logic [3:0]     init_nib;
  logic [7:0]     cmd_byte;
  logic [7:0]     char_byte;
  logic [IW-1:0]  rd_idx;
  logic [IW-1:0]  wr_idx;
  logic           wr_ok;
  logic           slot_end;

  assign lcd_rw    = 1'b0;
  assign wr_idx    = wr_addr[IW-1:0];
  assign wr_ok     = wr_en && ({1'b0, wr_addr} < DEPTH_A);
  assign rd_idx    = IW'(int'(row) * COLS + int'(col));
  assign char_byte = blank ? 8'h20 : char_mem[rd_idx];
  assign e_win     = (cnt >= e_on) && (cnt < e_off);
  assign slot_end  = (cnt == slot_last);

  always_comb begin
    if (state == INIT) begin
      slot_last = INIT_LAST;
      e_on      = INIT_E_ON;
      e_off     = INIT_E_OFF;
    end else begin
      slot_last = NIB_LAST;
      e_on      = NIB_E_ON;
      e_off     = NIB_E_OFF;
    end
  end

  // Rows 2 and 3 continue the DDRAM lines of rows 0 and 1 after COLS characters.
  always_comb begin
    cmd_byte = 8'h80;
    if (int'(row) == 1)      cmd_byte = 8'hC0;
    else if (int'(row) == 2) cmd_byte = 8'h80 | COLS_B;
    else if (int'(row) == 3) cmd_byte = 8'h80 | (8'h40 + COLS_B);
  end

  always_comb begin
    case (init_idx)
      4'd0, 4'd1, 4'd2: init_nib = 4'h3;
      4'd3, 4'd4:       init_nib = 4'h2;
      4'd5:             init_nib = 4'h8;
      4'd7:             init_nib = 4'hC;
      4'd9:             init_nib = 4'h1;
      4'd11:            init_nib = 4'h6;
      default:          init_nib = 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= POR_WAIT;
      cnt        <= '0;
      init_idx   <= '0;
      row        <= '0;
      col        <= '0;
      is_cmd     <= 1'b1;
      lo         <= 1'b0;
      hold       <= 8'h20;
      ready      <= 1'b0;
      frame_done <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_e      <= 1'b0;
      lcd_d      <= 4'h0;
      for (int i = 0; i < DEPTH; i++) char_mem[i] <= 8'h20;
    end else begin
      frame_done <= 1'b0;
      if (wr_ok) char_mem[wr_idx] <= wr_data;

      case (state)
        POR_WAIT: begin
          if (cnt == POR_LAST) begin
            cnt   <= '0;
            state <= INIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        INIT: begin
          lcd_rs <= 1'b0;
          lcd_e  <= e_win;
          if (cnt == '0) lcd_d <= init_nib;
          if (slot_end) begin
            cnt <= '0;
            if (init_idx == 4'd11) begin
              state    <= REFRESH;
              init_idx <= '0;
              row      <= '0;
              col      <= '0;
              is_cmd   <= 1'b1;
              lo       <= 1'b0;
            end else begin
              init_idx <= init_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        REFRESH: begin
          ready <= 1'b1;
          lcd_e <= e_win;
          if (cnt == '0) begin
            if (is_cmd) begin
              lcd_rs <= 1'b0;
              lcd_d  <= lo ? cmd_byte[3:0] : cmd_byte[7:4];
            end else begin
              lcd_rs <= 1'b1;
              if (!lo) begin
                // Latch the whole byte so both nibbles come from the same value.
                hold  <= char_byte;
                lcd_d <= char_byte[7:4];
              end else begin
                lcd_d <= hold[3:0];
              end
            end
          end
          if (slot_end) begin
            cnt <= '0;
            lo  <= ~lo;
            if (lo) begin
              if (is_cmd) begin
                is_cmd <= 1'b0;
                col    <= '0;
              end else if (col == COL_LAST) begin
                is_cmd <= 1'b1;
                col    <= '0;
                if (row == ROW_LAST) begin
                  row        <= '0;
                  frame_done <= 1'b1;
                end else begin
                  row <= row + 1'b1;
                end
              end else begin
                col <= col + 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= POR_WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Bench for lcd_char_ctrl: compares every output cycle against a slot-level
// model of the panel stream built from a shadow copy of the character buffer.
module tb_lcd_char_ctrl;

  localparam int ROWS   = 2;
  localparam int COLS   = 4;
  localparam int NIB    = 8;
  localparam int INIT_N = 16;
  localparam int POR    = 32;
  localparam int AW     = 4;
  localparam int SPR    = 2 + 2 * COLS;
  localparam int FSLOTS = ROWS * SPR;
  localparam logic [3:0] INIT_SEQ [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                           4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          blank = 1'b0;
  logic          ready, frame_done, lcd_rs, lcd_rw, lcd_e;
  logic [3:0]    lcd_d;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [ROWS*COLS];

  always #5 clk = ~clk;

  lcd_char_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .NIB_CYCLES(NIB), .INIT_NIB_CYCLES(INIT_N),
    .POR_CYCLES(POR), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .blank(blank), .ready(ready), .frame_done(frame_done), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (ready,fd,rs,e,d)", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pins();
    return {ready, frame_done, lcd_rs, lcd_e, lcd_d};
  endfunction

  function automatic logic [7:0] exp_pins(bit rdy, bit fd, bit rs, bit e, logic [3:0] d);
    return {rdy, fd, rs, e, d};
  endfunction

  function automatic bit e_win(int c, int n);
    return (c >= n / 4) && (c < (3 * n) / 4);
  endfunction

  task automatic reset_model();
    for (int i = 0; i < ROWS * COLS; i++) mem[i] = 8'h20;
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    if (int'(a) < ROWS * COLS) mem[int'(a)] = d;
  endtask

  task automatic run_init(input bit do_wr, input logic [AW-1:0] a, input logic [7:0] d);
    for (int i = 0; i < POR; i++) begin
      if (do_wr && i == 0) drive_write(a, d);
      tick();
      wr_en = 1'b0;
      check("por", pins(), 8'h00);
    end
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < INIT_N; c++) begin
        tick();
        check("init", pins(), exp_pins(1'b0, 1'b0, 1'b0, e_win(c, INIT_N), INIT_SEQ[k]));
      end
    end
  endtask

  // One full frame; optional forced writes land on the latch edge of a slot,
  // rnd adds random writes/blank toggles, abort_cyc pulls reset mid-frame.
  task automatic run_frame(input int f1_slot, input logic [AW-1:0] f1_a, input logic [7:0] f1_d,
                           input int f2_slot, input logic [AW-1:0] f2_a, input logic [7:0] f2_d,
                           input bit rnd, input int abort_cyc);
    int cyc = 0;
    int r, k, cidx;
    logic [7:0] byte_e;
    logic [7:0] held = 8'h20;
    logic [3:0] nib = 4'h0;
    bit rs = 1'b0;
    for (int s = 0; s < FSLOTS; s++) begin
      r = s / SPR;
      k = s % SPR;
      for (int c = 0; c < NIB; c++) begin
        if (cyc == abort_cyc) begin
          check("e_before_reset", {7'b0, lcd_e}, 8'h01);
          wr_en = 1'b0;
          rst_n = 1'b0;
          tick();
          check("reset_pins", pins(), 8'h00);
          reset_model();
          return;
        end
        if (c == 0) begin
          if (k < 2) begin
            byte_e = 8'h80 | 8'((r % 2) * 64 + (r / 2) * COLS);
            nib    = (k == 1) ? byte_e[3:0] : byte_e[7:4];
            rs     = 1'b0;
          end else begin
            cidx = (k - 2) / 2;
            if (((k - 2) % 2) == 0) begin
              held = blank ? 8'h20 : mem[r * COLS + cidx];
              nib  = held[7:4];
            end else begin
              nib = held[3:0];
            end
            rs = 1'b1;
          end
        end
        wr_en = 1'b0;
        if (c == 0 && s == f1_slot) drive_write(f1_a, f1_d);
        else if (c == 0 && s == f2_slot) drive_write(f2_a, f2_d);
        else if (rnd && $urandom_range(3) == 0)
          drive_write(4'($urandom_range(15)), 8'($urandom_range(255)));
        if (rnd && c == NIB - 1 && $urandom_range(7) == 0) blank = ~blank;
        tick();
        check("slot", pins(),
              exp_pins(1'b1, (s == FSLOTS - 1) && (c == NIB - 1), rs, e_win(c, NIB), nib));
        cyc++;
      end
    end
    wr_en = 1'b0;
  endtask

  initial begin
    reset_model();
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_pins", pins(), 8'h00);
    check("rw_low", {7'b0, lcd_rw}, 8'h00);

    rst_n = 1'b1;
    run_init(1'b0, '0, '0);
    run_frame(-1, '0, '0, -1, '0, '0, 1'b0, -1);
    run_frame(-1, '0, '0, -1, '0, '0, 1'b0, -1);
    run_frame(-1, '0, '0, -1, '0, '0, 1'b0, 21);

    rst_n = 1'b1;
    run_init(1'b1, 4'd5, 8'h41);
    run_frame(-1, '0, '0, -1, '0, '0, 1'b0, -1);
    run_frame(6, 4'd2, 8'h5A, 10, 4'd8, 8'h77, 1'b0, -1);
    run_frame(-1, '0, '0, -1, '0, '0, 1'b0, -1);
    check("rw_low_run", {7'b0, lcd_rw}, 8'h00);

    blank = 1'b1;
    run_frame(-1, '0, '0, -1, '0, '0, 1'b0, -1);
    blank = 1'b0;
    run_frame(-1, '0, '0, -1, '0, '0, 1'b0, -1);

    repeat (4) run_frame(-1, '0, '0, -1, '0, '0, 1'b1, -1);
    blank = 1'b0;
    run_frame(-1, '0, '0, -1, '0, '0, 1'b0, 45);

    rst_n = 1'b1;
    run_init(1'b0, '0, '0);
    run_frame(-1, '0, '0, -1, '0, '0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_char_ctrl.md
Name: lcd_char_ctrl

Overview:
- Parametrised HD44780-class character LCD controller, 4-bit interface, write-only (lcd_rw tied low).
- Owns an internal ROWS×COLS character buffer written by the CPU-side bus decoder and refreshed to the panel continuously.
- Generalises the fixed 2×16 driver: configurable geometry and timing, per-row DDRAM addressing for 1–4 rows, a synchronous write port, a ready flag, a frame-done pulse, and a display blank control.

Parameters:
- ROWS, 2, number of display rows (1..4).
- COLS, 16, characters per row (1..40).
- NIB_CYCLES, 8192, clk cycles per nibble slot during refresh (multiple of 4, ≥8).
- INIT_NIB_CYCLES, 524288, clk cycles per nibble slot during initialisation (multiple of 4).
- POR_CYCLES, 1000000, power-on wait before the first init nibble.
- AW, $clog2(ROWS*COLS), buffer address width.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous reset, active low.
- wr_en, input, 1, buffer write strobe.
- wr_addr, input, AW, buffer index = row*COLS+col.
- wr_data, input, 8, character code.
- blank, input, 1, 1 = send spaces instead of buffer contents.
- ready, output, 1, init complete, refresh running.
- frame_done, output, 1, one-cycle pulse after the last nibble of a full frame.
- lcd_rs, output, 1, register select.
- lcd_rw, output, 1, always 0.
- lcd_e, output, 1, enable strobe.
- lcd_d, output, 4, data nibble (panel D7..D4).

Behaviour:
- Reset (rst_n=0 at posedge clk): all outputs 0; all buffer entries = 8'h20; FSM returns to POR_WAIT; slot counter 0. Reset mid-transfer drops lcd_e the next cycle with no completion of the nibble.
- Nibble slot: counter runs 0..N-1, N = NIB_CYCLES or INIT_NIB_CYCLES.
  - lcd_rs/lcd_d registered at count 0 and held for the whole slot.
  - lcd_e = 1 for count in [N/4, 3N/4), otherwise 0.
- FSM states:
  - POR_WAIT: POR_CYCLES cycles, outputs 0, then INIT.
  - INIT: INIT_NIB_CYCLES slots, rs=0, nibbles in order: 3, 3, 3, 2, then pairs 2,8 (function set), 0,C (display on), 0,1 (clear), 0,6 (entry mode). Twelve slots total, then REFRESH.
  - REFRESH: for r = 0..ROWS-1:
    - Cursor command, rs=0, two nibbles of 8'h80|base(r). base = 0x00, 0x40, COLS, 0x40+COLS for r = 0..3.
    - Then COLS characters, rs=1, high nibble then low nibble.
    - After the last row: frame_done pulses with the last slot's final cycle; the next frame starts on the next cycle with row 0.
- ready: 0 until INIT completes; 1 from the first REFRESH cycle until reset.
- Character latch: the byte is captured into a holding register on count 0 of its high-nibble slot. The low nibble uses the same byte, so there is no tearing.
- Write port:
  - Single-cycle synchronous write, accepted in any state including POR_WAIT and INIT.
  - wr_addr ≥ ROWS*COLS is ignored.
  - A write to the entry being latched in the same cycle: the old value is displayed this frame and the new value next frame.
- blank: sampled at each character latch; if 1, the latched byte is 8'h20. Buffer contents are unaffected.
- Geometry arithmetic: the row/column counters must not wrap into a wrong row. Column wraps at COLS-1 to the next row's cursor command; row wraps at ROWS-1 to 0.
- Frame length: ROWS*(2+2*COLS)*NIB_CYCLES cycles.

Test Plan (bench params ROWS=2, COLS=4, NIB_CYCLES=8, INIT_NIB_CYCLES=16, POR_CYCLES=32):
- Release reset → lcd_e/lcd_d/lcd_rs = 0 for 32 cycles. Then 12 init slots carry nibbles 3,3,3,2,2,8,0,C,0,1,0,6 with rs=0 and lcd_e high on counts 4..11 of each 16-cycle slot. ready rises at cycle 224.
- No writes → first frame sends nibbles 8,0, then 2,0 ×4 with rs=1, then C,0, then 2,0 ×4. frame_done pulses once at cycle 224+160-1; the second frame repeats the same sequence.
- Write addr 5 = 8'h41 before ready → row 1 col 1 outputs nibbles 4,1 with rs=1; all other characters show 2,0.
- Write addr 2 = 8'h5A on count 0 of that character's high slot → this frame shows 2,0 and the next frame shows 5,A. A write to addr 8 (out of range) changes nothing.
- blank=1 after a buffer write of 8'h41 → all characters show 2,0. Deassert blank → 4,1 reappears next frame with no reinit.
- Assert rst_n=0 mid-refresh while lcd_e=1 → lcd_e=0 and ready=0 the following cycle, buffer returns to 8'h20, and the full POR+INIT sequence replays.
